// File: rtl/seg7_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_chain_driver
// Purpose  : Display back-end for the calculator core. Accepts one result
//            word over a ready/valid handshake, converts it to decimal (an
//            iterative double-dabble) or hex digits, and applies leading-zero
//            blanking, sign placement and overflow-to-"Err" substitution.
//            It then shifts the segment bytes MSB-first into a daisy chain
//            of 74HC595-style registers and pulses the storage latch.
// Ports    : clk            system clock, rising edge
//            rst_n          asynchronous active-low reset
//            i_data         unsigned magnitude to display
//            i_error        force the "Err" pattern
//            i_data_is_neg  prefix a minus sign (decimal only)
//            i_hex_mode     1 = hexadecimal, 0 = decimal
//            i_valid        input word valid
//            o_ready        idle, can accept a word
//            o_sr_data      serial data to the first shift register
//            o_sr_clk       serial shift clock
//            o_sr_latch     storage-register latch pulse
//            o_sr_oe_n      active-low display output enable
// Revision : 1.0  initial release
// ============================================================================
module seg7_chain_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_error,
    input  logic                  i_data_is_neg,
    input  logic                  i_hex_mode,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch,
    output logic                  o_sr_oe_n
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    // Decimal digits needed for 2^DATA_WIDTH-1 is floor(W*log10(2))+1; one
    // spare digit absorbs any rounding in the integer approximation of log10(2).
    localparam int c_bcd_digits  = (DATA_WIDTH * 30103) / 100000 + 2;
    localparam int c_hex_digits  = (DATA_WIDTH + 3) / 4;
    localparam int c_max_conv    = (c_bcd_digits > c_hex_digits) ? c_bcd_digits : c_hex_digits;
    // Working digit store must also cover every displayed position so that
    // significance (and hence overflow) is judged over all converted digits.
    localparam int c_work_digits = (c_max_conv > NUM_DIGITS) ? c_max_conv : NUM_DIGITS;
    localparam int c_work_bits   = 4 * c_work_digits;
    localparam int c_frame_bits  = 8 * NUM_DIGITS;

    localparam int c_bit_cnt_w   = $clog2(c_frame_bits);
    localparam int c_div_cnt_w   = $clog2(CLK_DIV + 1);
    localparam int c_conv_cnt_w  = $clog2(DATA_WIDTH + 1);

    localparam logic [c_bit_cnt_w-1:0]  c_last_bit  = c_bit_cnt_w'(c_frame_bits - 1);
    localparam logic [c_div_cnt_w-1:0]  c_last_div  = c_div_cnt_w'(CLK_DIV - 1);
    localparam logic [c_conv_cnt_w-1:0] c_last_conv = c_conv_cnt_w'(DATA_WIDTH - 1);

    // Segment byte is {dp,g,f,e,d,c,b,a}, active high
    localparam logic [7:0] c_seg_blank = 8'h00;
    localparam logic [7:0] c_seg_minus = 8'h40;
    localparam logic [7:0] c_seg_e     = 8'h79;
    localparam logic [7:0] c_seg_r     = 8'h50;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_ENCODE  = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_LATCH   = 3'd4
    } state_t;

    state_t                    state_q,    state_d;
    logic [DATA_WIDTH-1:0]     bin_q,      bin_d;
    logic                      err_q,      err_d;
    logic                      neg_q,      neg_d;
    logic                      hex_q,      hex_d;
    logic [c_work_bits-1:0]    bcd_q,      bcd_d;
    logic [c_conv_cnt_w-1:0]   conv_cnt_q, conv_cnt_d;
    logic [c_frame_bits-1:0]   frame_q,    frame_d;
    logic [c_bit_cnt_w-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [c_div_cnt_w-1:0]    div_cnt_q,  div_cnt_d;
    logic                      ready_q,    ready_d;
    logic                      sr_data_q,  sr_data_d;
    logic                      sr_clk_q,   sr_clk_d;
    logic                      sr_latch_q, sr_latch_d;
    logic                      sr_oe_n_q,  sr_oe_n_d;

    logic [c_work_bits-1:0]    w_bcd_adj;
    logic [c_frame_bits-1:0]   w_frame;

    // ------------------------------------------------------------------
    // Glyph lookup for a single hex/BCD digit
    // ------------------------------------------------------------------
    function automatic logic [7:0] glyph(input logic [3:0] dig);
        logic [7:0] seg;
        case (dig)
            4'h0:    seg = 8'h3F;
            4'h1:    seg = 8'h06;
            4'h2:    seg = 8'h5B;
            4'h3:    seg = 8'h4F;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'h6D;
            4'h6:    seg = 8'h7D;
            4'h7:    seg = 8'h07;
            4'h8:    seg = 8'h7F;
            4'h9:    seg = 8'h6F;
            4'hA:    seg = 8'h77;
            4'hB:    seg = 8'h7C;
            4'hC:    seg = 8'h39;
            4'hD:    seg = 8'h5E;
            4'hE:    seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Double-dabble correction: every BCD digit >= 5 gets +3 before the
    // shift so that the shift carries correctly into the next decade.
    // ------------------------------------------------------------------
    always_comb begin : p_dabble_adjust
        w_bcd_adj = bcd_q;
        for (int i = 0; i < c_work_digits; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame encoder: blanking, sign, overflow and error substitution.
    // Digit 0 sits in the low byte so that the top byte shifts out first.
    // ------------------------------------------------------------------
    always_comb begin : p_encode
        int         msd;
        logic       show_neg;
        logic       show_err;
        logic [7:0] seg;

        msd = 0;
        for (int i = 0; i < c_work_digits; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end

        show_neg = neg_q && !hex_q;
        // Significant digits plus the sign position must fit in the chain
        show_err = err_q || ((msd + 1 + (show_neg ? 1 : 0)) > NUM_DIGITS);

        w_frame = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg = c_seg_blank;
            if (show_err) begin
                if (i == 2) begin
                    seg = c_seg_e;
                end else if (i < 2) begin
                    seg = c_seg_r;
                end
            end else if (i <= msd) begin
                seg = glyph(bcd_q[4*i +: 4]);
            end else if (show_neg && (i == msd + 1)) begin
                seg = c_seg_minus;
            end
            w_frame[8*i +: 8] = seg;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin : p_next
        state_d    = state_q;
        bin_d      = bin_q;
        err_d      = err_q;
        neg_d      = neg_q;
        hex_d      = hex_q;
        bcd_d      = bcd_q;
        conv_cnt_d = conv_cnt_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        ready_d    = ready_q;
        sr_data_d  = sr_data_q;
        sr_clk_d   = sr_clk_q;
        sr_latch_d = sr_latch_q;
        sr_oe_n_d  = sr_oe_n_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid && ready_q) begin
                    bin_d      = i_data;
                    err_d      = i_error;
                    neg_d      = i_data_is_neg;
                    hex_d      = i_hex_mode;
                    bcd_d      = '0;
                    conv_cnt_d = '0;
                    ready_d    = 1'b0;
                    state_d    = ST_CONVERT;
                end
            end

            ST_CONVERT: begin
                if (hex_q || err_q) begin
                    // Hex digits are the nibbles themselves; in error mode
                    // the digit content is discarded by the encoder anyway.
                    bcd_d                   = '0;
                    bcd_d[DATA_WIDTH-1:0]   = bin_q;
                    state_d                 = ST_ENCODE;
                end else begin
                    bcd_d      = {w_bcd_adj[c_work_bits-2:0], bin_q[DATA_WIDTH-1]};
                    bin_d      = bin_q << 1;
                    conv_cnt_d = conv_cnt_q + c_conv_cnt_w'(1);
                    if (conv_cnt_q == c_last_conv) begin
                        state_d = ST_ENCODE;
                    end
                end
            end

            ST_ENCODE: begin
                // First bit is presented together with the low serial-clock phase
                frame_d   = w_frame;
                sr_data_d = w_frame[c_frame_bits-1];
                sr_clk_d  = 1'b0;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (div_cnt_q == c_last_div) begin
                    div_cnt_d = '0;
                    if (!sr_clk_q) begin
                        sr_clk_d = 1'b1;
                    end else begin
                        // Falling edge ends the bit; data for the next bit
                        // changes on the same edge, while the clock is low.
                        sr_clk_d = 1'b0;
                        if (bit_cnt_q == c_last_bit) begin
                            sr_latch_d = 1'b1;
                            state_d    = ST_LATCH;
                        end else begin
                            bit_cnt_d = bit_cnt_q + c_bit_cnt_w'(1);
                            frame_d   = frame_q << 1;
                            sr_data_d = frame_q[c_frame_bits-2];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + c_div_cnt_w'(1);
                end
            end

            ST_LATCH: begin
                if (div_cnt_q == c_last_div) begin
                    div_cnt_d  = '0;
                    sr_latch_d = 1'b0;
                    // Display stays dark until the first complete frame is latched
                    sr_oe_n_d  = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + c_div_cnt_w'(1);
                end
            end

            default: begin
                sr_clk_d   = 1'b0;
                sr_latch_d = 1'b0;
                ready_d    = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            err_q      <= 1'b0;
            neg_q      <= 1'b0;
            hex_q      <= 1'b0;
            bcd_q      <= '0;
            conv_cnt_q <= '0;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            ready_q    <= 1'b1;
            sr_data_q  <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
            sr_oe_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
            neg_q      <= neg_d;
            hex_q      <= hex_d;
            bcd_q      <= bcd_d;
            conv_cnt_q <= conv_cnt_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            ready_q    <= ready_d;
            sr_data_q  <= sr_data_d;
            sr_clk_q   <= sr_clk_d;
            sr_latch_q <= sr_latch_d;
            sr_oe_n_q  <= sr_oe_n_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_sr_data  = sr_data_q;
    assign o_sr_clk   = sr_clk_q;
    assign o_sr_latch = sr_latch_q;
    assign o_sr_oe_n  = sr_oe_n_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_chain_driver
// Purpose  : Self-checking bench for seg7_chain_driver. Two instances: the
//            default configuration (16 bit, 5 digits, CLK_DIV 2) and a small
//            one (16 bit, 3 digits, CLK_DIV 1). A vector table drives whole
//            frames; the serial stream is reassembled from the o_sr_clk
//            rising edges and compared with hand-computed segment bytes.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_chain_driver;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data = '0;
    logic         err = 1'b0;
    logic         neg = 1'b0;
    logic         hex = 1'b0;
    logic         valid = 1'b0;
    logic         sel = 1'b0;

    logic ready_a, sdat_a, sclk_a, latch_a, oe_a;
    logic ready_b, sdat_b, sclk_b, latch_b, oe_b;
    logic valid_a, valid_b;

    assign valid_a = valid & ~sel;
    assign valid_b = valid & sel;

    always #5 clk = ~clk;

    seg7_chain_driver #(.DATA_WIDTH(W), .NUM_DIGITS(5), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_error(err),
        .i_data_is_neg(neg), .i_hex_mode(hex), .i_valid(valid_a),
        .o_ready(ready_a), .o_sr_data(sdat_a), .o_sr_clk(sclk_a),
        .o_sr_latch(latch_a), .o_sr_oe_n(oe_a)
    );

    seg7_chain_driver #(.DATA_WIDTH(W), .NUM_DIGITS(3), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_error(err),
        .i_data_is_neg(neg), .i_hex_mode(hex), .i_valid(valid_b),
        .o_ready(ready_b), .o_sr_data(sdat_b), .o_sr_clk(sclk_b),
        .o_sr_latch(latch_b), .o_sr_oe_n(oe_b)
    );

    wire m_ready = sel ? ready_b : ready_a;
    wire m_sdat  = sel ? sdat_b  : sdat_a;
    wire m_sclk  = sel ? sclk_b  : sclk_a;
    wire m_latch = sel ? latch_b : latch_a;
    wire m_oe    = sel ? oe_b    : oe_a;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Watches one frame from the cycle after acceptance until o_ready is
    // seen high again (or stop_bits bits have been shifted, if non-zero).
    task automatic capture(input int stop_bits, input bit scramble, input int ndig,
                           output logic [39:0] cap, output int nbits, output int busy,
                           output int nlatch, output int lcyc, output int bad,
                           output logic oe_lat, output bit timeout);
        logic pclk, platch, pdat;
        bit   done;
        int   c;
        cap = '0; nbits = 0; busy = 0; nlatch = 0; lcyc = 0; bad = 0;
        oe_lat = 1'bx; timeout = 0; done = 0; c = 0;
        pclk = m_sclk; platch = m_latch; pdat = m_sdat;
        while (!done && c < 2000) begin
            @(negedge clk);
            c++;
            if (m_ready) begin
                done = 1;
            end else begin
                busy++;
                if (m_sclk && !pclk) begin
                    cap = {cap[38:0], m_sdat};
                    nbits++;
                end
                if (m_sclk && (m_sdat !== pdat)) bad++;   // data moved while clock high
                if (m_sclk && m_latch) bad++;             // clock and latch overlap
                if (m_latch && (nbits != 8 * ndig)) bad++; // latch before all bits
                if (m_latch) lcyc++;
                if (m_latch && !platch) begin
                    nlatch++;
                    oe_lat = m_oe;
                end
                pclk = m_sclk; platch = m_latch; pdat = m_sdat;
                if (scramble) data = W'($urandom);
                if (stop_bits != 0 && nbits == stop_bits) done = 1;
            end
        end
        if (!done) timeout = 1;
    endtask

    typedef struct {
        logic         sel;
        logic [W-1:0] data;
        logic         err;
        logic         neg;
        logic         hex;
        logic [39:0]  exp;
        int           busy;
        logic         oe_lat;
    } vec_t;

    task automatic run_vec(input string name, input vec_t v);
        logic [39:0] cap;
        int nb, busy, nl, lc, bad, ndig, div;
        logic oel;
        bit to;
        ndig = v.sel ? 3 : 5;
        div  = v.sel ? 1 : 2;
        @(negedge clk);
        sel = v.sel; data = v.data; err = v.err; neg = v.neg; hex = v.hex; valid = 1'b1;
        chk({name, " ready_before"}, m_ready, 1);
        @(posedge clk);
        #1 valid = 1'b0;
        capture(0, 0, ndig, cap, nb, busy, nl, lc, bad, oel, to);
        chk({name, " timeout"}, to, 0);
        chk({name, " bytes"}, cap, v.exp);
        chk({name, " nbits"}, nb, 8 * ndig);
        chk({name, " busy"}, busy, v.busy);
        chk({name, " latch_pulses"}, nl, 1);
        chk({name, " latch_cycles"}, lc, div);
        chk({name, " timing_violations"}, bad, 0);
        chk({name, " oe_during_latch"}, oel, v.oe_lat);
        chk({name, " oe_after"}, m_oe, 0);
    endtask

    vec_t vecs[13];

    initial begin
        logic [39:0] cap;
        int nb, busy, nl, lc, bad;
        logic oel;
        bit to;

        //            sel   data      err   neg   hex   expected bytes   busy oe@latch
        vecs[0]  = '{1'b0, 16'd12345, 1'b0, 1'b0, 1'b0, 40'h065B4F666D, 179, 1'b1};
        vecs[1]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 40'h000000003F, 179, 1'b0};
        vecs[2]  = '{1'b0, 16'd42,    1'b0, 1'b1, 1'b0, 40'h000040665B, 179, 1'b0};
        vecs[3]  = '{1'b0, 16'd65535, 1'b0, 1'b1, 1'b0, 40'h0000795050, 179, 1'b0};
        vecs[4]  = '{1'b0, 16'd65535, 1'b0, 1'b0, 1'b0, 40'h7D6D6D4F6D, 179, 1'b0};
        vecs[5]  = '{1'b0, 16'd9999,  1'b0, 1'b1, 1'b0, 40'h406F6F6F6F, 179, 1'b0};
        vecs[6]  = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 40'h000000403F, 179, 1'b0};
        vecs[7]  = '{1'b0, 16'hBEEF,  1'b0, 1'b1, 1'b1, 40'h007C797971, 164, 1'b0};
        vecs[8]  = '{1'b0, 16'h000A,  1'b0, 1'b0, 1'b1, 40'h0000000077, 164, 1'b0};
        vecs[9]  = '{1'b0, 16'd7,     1'b1, 1'b0, 1'b0, 40'h0000795050, 164, 1'b0};
        vecs[10] = '{1'b1, 16'd1000,  1'b0, 1'b0, 1'b0, 40'h0000795050,  66, 1'b1};
        vecs[11] = '{1'b1, 16'd999,   1'b0, 1'b0, 1'b0, 40'h00006F6F6F,  66, 1'b0};
        vecs[12] = '{1'b1, 16'h0123,  1'b0, 1'b0, 1'b1, 40'h0000065B4F,  51, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ready_a", ready_a, 1);
        chk("reset sdat_a",  sdat_a,  0);
        chk("reset sclk_a",  sclk_a,  0);
        chk("reset latch_a", latch_a, 0);
        chk("reset oe_a",    oe_a,    1);
        chk("reset ready_b", ready_b, 1);
        chk("reset oe_b",    oe_b,    1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle oe_a", oe_a, 1);

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Valid held high with data changing during the frame; the next
        // word is taken on the edge where o_ready returns.
        @(negedge clk);
        sel = 1'b0; data = 16'd111; err = 1'b0; neg = 1'b0; hex = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        capture(0, 1, 5, cap, nb, busy, nl, lc, bad, oel, to);
        chk("hold1 timeout", to, 0);
        chk("hold1 bytes", cap, 40'h0000060606);
        chk("hold1 busy", busy, 179);
        data = 16'd222;            // present at the edge where o_ready is high
        @(posedge clk);
        #1 valid = 1'b0;
        capture(0, 0, 5, cap, nb, busy, nl, lc, bad, oel, to);
        chk("hold2 timeout", to, 0);
        chk("hold2 bytes", cap, 40'h00005B5B5B);
        chk("hold2 busy_back_to_back", busy, 179);
        chk("hold2 violations", bad, 0);

        // Reset in the middle of SHIFT
        @(negedge clk);
        sel = 1'b0; data = 16'd12345; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        capture(20, 0, 5, cap, nb, busy, nl, lc, bad, oel, to);
        chk("midrst timeout", to, 0);
        chk("midrst nbits", nb, 20);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", ready_a, 1);
        chk("midrst sdat",  sdat_a,  0);
        chk("midrst sclk",  sclk_a,  0);
        chk("midrst latch", latch_a, 0);
        chk("midrst oe",    oe_a,    1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_reset", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_chain_driver.md
# seg7_chain_driver

Parametrised display back-end that takes one result word from the calculator core and drives a daisy-chain of 74HC595-style shift registers feeding NUM_DIGITS seven-segment digits. It is the successor to the fixed-width output driver. New features: run-time decimal/hex radix, leading-zero blanking, sign placement, overflow-to-error detection and a programmable serial clock rate. It sits between the core's display ready/valid port and the chip output pins.

## Interface
- DATA_WIDTH, 16: width of the input magnitude, ≥4.
- NUM_DIGITS, 5: number of digits in the chain, ≥3.
- CLK_DIV, 2: clk cycles per serial-clock phase, ≥1.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_data  in  DATA_WIDTH  unsigned magnitude to display.
- i_error  in  1  show the error pattern instead of i_data.
- i_data_is_neg  in  1  prefix a minus sign (decimal mode only).
- i_hex_mode  in  1  1 = hexadecimal, 0 = decimal.
- i_valid  in  1  input word valid.
- o_ready  out  1  driver idle and able to accept a word.
- o_sr_data  out  1  serial data to the first register.
- o_sr_clk  out  1  serial shift clock.
- o_sr_latch  out  1  storage-register latch pulse.
- o_sr_oe_n  out  1  active-low display output enable.

## Operation
- **FSM:** IDLE → CONVERT → ENCODE → SHIFT → LATCH → IDLE.
- **IDLE:** o_ready=1. On i_valid&&o_ready, register all inputs and go to CONVERT. Inputs are ignored at all other times.
- **CONVERT, decimal:** iterative double-dabble, one bit per cycle, DATA_WIDTH cycles.
- **CONVERT, hex or error:** nibble copy, 1 cycle.
- **ENCODE (1 cycle):** build NUM_DIGITS bytes. Digit 0 is rightmost. Segment byte is {dp,g,f,e,d,c,b,a}, active-high, dp always 0.
- **Glyphs:**
  - digits 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
  - blank 00, minus 40, E 79, r 50
- **Leading-zero blanking:** digits above the most significant nonzero digit are blank. Digit 0 is always shown, so value 0 displays "0".
- **Sign:** when decimal and i_data_is_neg, a minus goes in the digit directly left of the most significant shown digit. i_data_is_neg is ignored in hex mode. Negative zero displays "-0".
- **Overflow:** if significant digits plus sign exceed NUM_DIGITS, display the error pattern.
- **Error pattern:** digits 2,1,0 = E,r,r; all others blank. It is used when i_error=1 or on overflow.
- **SHIFT:** 8·NUM_DIGITS bits, MSB-first, starting with bit 7 of digit NUM_DIGITS-1 and ending with bit 0 of digit 0.
- **LATCH:** o_sr_latch high for CLK_DIV cycles.
- **Output enable:** o_sr_oe_n stays 1 from reset until the first LATCH phase ends, then stays 0 until the next reset.

## Timing
- **Reset values:** o_ready=1, o_sr_data=0, o_sr_clk=0, o_sr_latch=0, o_sr_oe_n=1. FSM returns to IDLE.
- **Reset mid-operation:** the frame is aborted and every output takes its reset value immediately (asynchronous).
- **Acceptance:** the word is taken at edge T0. o_ready is 0 from T0+1 until it returns to 1.
- **Per-bit timing:**
  - o_sr_data updates only while o_sr_clk=0, at the start of each bit.
  - o_sr_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - After the last bit o_sr_clk is left at 0.
- **Latch timing:** the latch pulse starts in the cycle after the last o_sr_clk falling edge. o_sr_clk and o_sr_latch are never high together.
- **Busy time:** C + 1 + 16·NUM_DIGITS·CLK_DIV + CLK_DIV cycles, where C = DATA_WIDTH for decimal and C = 1 for hex/error.
  - Defaults, decimal: 179 cycles.
  - Defaults, hex: 164 cycles.
- **Back-to-back:** o_ready=1 in the cycle after LATCH ends. A word held valid at that point is accepted on that edge, so there is zero dead cycles between frames.

## Test plan
- **Decimal 12345:** reset, then send 12345 decimal → serial bytes 06 5B 4F 66 6D (digit4→digit0), one latch pulse. o_sr_oe_n falls at latch end. o_ready is low for exactly 179 cycles.
- **Blanking and sign:**
  - 0 → 00 00 00 00 3F.
  - 42 with i_data_is_neg → 00 00 40 66 5B.
  - 65535 with i_data_is_neg → overflow → 00 00 79 50 50.
- **Hex mode:** 0xBEEF with i_data_is_neg=1 → 00 7C 79 79 71 (sign ignored). o_ready low 164 cycles.
- **Error:** i_error=1, i_data=7 → 00 00 79 50 50.
- **Handshake:**
  - Hold i_valid high with a changing i_data throughout a frame → only the word present at acceptance is displayed.
  - The next frame starts on the edge where o_ready returns to 1.
- **Reset mid-SHIFT:** assert rst_n=0 at bit 20 → all outputs return to reset values at once, including o_sr_oe_n=1. The next frame shifts complete and correct.
- **Parameter sweep:** NUM_DIGITS=3, CLK_DIV=1, value 1000 → Err. Value 999 → 6F 6F 6F with a 2-cycle bit period.
